// File: rtl/nn_pkg.sv
// Shared constants, address map and enums for the 2-10-1 phase-detector
// network sequencer.
package nn_pkg;
   localparam int unsigned N_HID       = 10;
   localparam int unsigned IN_W        = 9;
   localparam int unsigned W_W         = 8;
   localparam int unsigned ACC_W       = 17;
   localparam int unsigned OUT_W       = 8;
   localparam int unsigned AD_W        = 6;

   localparam int unsigned ADDR_B1_OFS = 2;
   localparam int unsigned ADDR_W2     = 3 * N_HID;
   localparam int unsigned ADDR_B2     = ADDR_W2 + N_HID;
   localparam int unsigned LAST_ADDR   = ADDR_B2;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_HID, S_OUT} state_t;
   typedef enum logic       {MAC_MUL, MAC_BIAS}            mac_sel_t;
   typedef enum logic [1:0] {SRC_IN1, SRC_IN2, SRC_H}      src_t;
endpackage

// File: rtl/nn_mac.sv
// Shared multiply-accumulate unit: unsigned 9-bit operand times signed
// coefficient, or sign-extended bias, into a wrapping ACC_W accumulator.
module nn_mac
   import nn_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  mac_sel_t         sel,
   input  logic             clr,
   input  logic             en,
   input  logic [W_W-1:0]   coeff,
   input  logic [IN_W-1:0]  opnd,
   output logic [ACC_W-1:0] acc
);
   logic signed [ACC_W-1:0] opnd_x;
   logic signed [ACC_W-1:0] coeff_x;
   logic signed [ACC_W-1:0] term;

   // Product is formed directly at ACC_W width; the low bits match the
   // truncated full-width product.
   always_comb begin
      opnd_x  = ACC_W'({1'b0, opnd});
      coeff_x = ACC_W'($signed(coeff));
      term    = (sel == MAC_BIAS) ? coeff_x : opnd_x * coeff_x;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (en) begin
         acc <= clr ? term : acc + term;
      end
   end
endmodule

// File: rtl/nn_seq_sched.sv
// Time-multiplexed sequencer: one MAC, one sync ROM port and one external
// activation shared across 10 hidden neurons and the output neuron.
module nn_seq_sched
   import nn_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [IN_W-1:0]  in1,
   input  logic [IN_W-1:0]  in2,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] out1,
   output logic             coeff_rd,
   output logic [AD_W-1:0]  coeff_addr,
   input  logic [W_W-1:0]   coeff_data,
   output logic [ACC_W-1:0] act_in,
   input  logic [ACC_W-1:0] act_out
);
   localparam logic [3:0]      HID_LAST = 4'(N_HID - 1);
   localparam logic [3:0]      OUT_LAST = 4'(ADDR_B2 - ADDR_W2);
   localparam logic [1:0]      PH_BIAS  = 2'(ADDR_B1_OFS);
   localparam logic [AD_W-1:0] ADDR_END = AD_W'(LAST_ADDR);

   state_t            state, nstate;
   logic [1:0]        ph;
   logic [3:0]        nidx;
   logic [IN_W-1:0]   in1_q, in2_q;
   logic [IN_W-1:0]   h [N_HID];

   logic              mac_en, mac_clr, h_cap, out_cap;
   mac_sel_t          mac_sel;
   src_t              src;
   logic [3:0]        cap_idx;
   logic [IN_W-1:0]   opnd;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  bias_x, sum;
   logic [OUT_W-1:0]  clamp;
   logic              unused_act;

   nn_mac u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (mac_sel),
      .clr   (mac_clr),
      .en    (mac_en),
      .coeff (coeff_data),
      .opnd  (opnd),
      .acc   (acc)
   );

   assign act_in     = acc;
   assign coeff_rd   = busy;
   assign unused_act = ^act_out[ACC_W-1:IN_W];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= nstate;
   end

   always_comb begin
      nstate = state;
      case (state)
         S_IDLE:  if (start) nstate = S_FILL;
         S_FILL:  nstate = S_HID;
         S_HID:   if (ph == PH_BIAS && nidx == HID_LAST) nstate = S_OUT;
         S_OUT:   if (nidx == OUT_LAST) nstate = S_IDLE;
         default: nstate = S_IDLE;
      endcase
   end

   // h[j-1] is captured while neuron j starts; the last hidden neuron
   // finishes only as the output layer begins, so h[9] lands in w2[0].
   always_comb begin
      busy    = 1'b0;
      mac_en  = 1'b0;
      mac_clr = 1'b0;
      mac_sel = MAC_MUL;
      src     = SRC_H;
      h_cap   = 1'b0;
      cap_idx = nidx - 4'd1;
      out_cap = 1'b0;
      case (state)
         S_FILL: busy = 1'b1;
         S_HID: begin
            busy   = 1'b1;
            mac_en = 1'b1;
            if (ph == 2'd0) begin
               mac_clr = 1'b1;
               src     = SRC_IN1;
               h_cap   = (nidx != 4'd0);
            end else if (ph == 2'd1) begin
               src = SRC_IN2;
            end else begin
               mac_sel = MAC_BIAS;
            end
         end
         S_OUT: begin
            busy = 1'b1;
            if (nidx == OUT_LAST) begin
               out_cap = 1'b1;
            end else begin
               mac_en  = 1'b1;
               mac_clr = (nidx == 4'd0);
               h_cap   = (nidx == 4'd0);
               cap_idx = HID_LAST;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      case (src)
         SRC_IN1: opnd = in1_q;
         SRC_IN2: opnd = in2_q;
         default: opnd = (nidx <= HID_LAST) ? h[nidx] : '0;
      endcase
      bias_x = ACC_W'($signed(coeff_data));
      sum    = acc + bias_x;
      if (sum[ACC_W-1])             clamp = '0;
      else if (|sum[ACC_W-2:OUT_W]) clamp = '1;
      else                          clamp = sum[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph         <= '0;
         nidx       <= '0;
         in1_q      <= '0;
         in2_q      <= '0;
         coeff_addr <= '0;
         out1       <= '0;
         done       <= 1'b0;
         for (int unsigned i = 0; i < N_HID; i++) h[i] <= '0;
      end else begin
         done <= out_cap;
         if (out_cap) out1 <= clamp;
         if (h_cap) h[cap_idx] <= act_out[IN_W-1:0];
         if (busy && coeff_addr != ADDR_END) coeff_addr <= coeff_addr + 6'd1;
         case (state)
            S_IDLE: if (start) begin
               in1_q      <= in1;
               in2_q      <= in2;
               coeff_addr <= '0;
            end
            S_FILL: begin
               ph   <= '0;
               nidx <= '0;
            end
            S_HID: begin
               if (ph == PH_BIAS) begin
                  ph   <= '0;
                  nidx <= (nidx == HID_LAST) ? '0 : nidx + 4'd1;
               end else begin
                  ph <= ph + 2'd1;
               end
            end
            S_OUT: nidx <= nidx + 4'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_nn_seq_sched.sv
// Randomized self-checking bench for nn_seq_sched with a sync ROM model,
// a pluggable combinational activation and an arithmetic reference model.
module tb_nn_seq_sched;
   import nn_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [IN_W-1:0]  in1 = '0, in2 = '0;
   logic             busy, done, coeff_rd;
   logic [OUT_W-1:0] out1;
   logic [AD_W-1:0]  coeff_addr;
   logic [W_W-1:0]   coeff_data;
   logic [ACC_W-1:0] act_in, act_out;

   logic [7:0] rom [64];
   int act_mode = 0;
   int tests = 0;
   int fails = 0;

   int obs_bfirst, obs_blast, obs_bcnt, obs_dcyc, obs_ndone, obs_early;
   logic [7:0] obs_res;
   int addr_q[$];

   nn_seq_sched dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in1        (in1),
      .in2        (in2),
      .busy       (busy),
      .done       (done),
      .out1       (out1),
      .coeff_rd   (coeff_rd),
      .coeff_addr (coeff_addr),
      .coeff_data (coeff_data),
      .act_in     (act_in),
      .act_out    (act_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) coeff_data <= rom[coeff_addr];

   function automatic logic [16:0] act_fn(input logic [16:0] x, input int m);
      case (m)
         1:       return x[16] ? 17'd0 : {1'b0, x[16:1]};
         2:       return x + 17'd37;
         default: return x;
      endcase
   endfunction

   always_comb act_out = act_fn(act_in, act_mode);

   function automatic int sx8(input logic [7:0] v);
      return int'($signed(v));
   endfunction

   // Whole-network evaluation from the ROM contents with plain integers.
   function automatic int ref_out(input int a, input int b);
      int s, o;
      int hv [N_HID];
      logic [16:0] av;
      for (int j = 0; j < N_HID; j++) begin
         s = sx8(rom[3*j]) * a + sx8(rom[3*j+1]) * b + sx8(rom[3*j+2]);
         av = act_fn(17'(s), act_mode);
         hv[j] = int'(av[8:0]);
      end
      o = sx8(rom[ADDR_B2]);
      for (int j = 0; j < N_HID; j++) o += sx8(rom[ADDR_W2 + j]) * hv[j];
      av = 17'(o);
      o = int'($signed(av));
      if (o < 0) return 0;
      if (o > 255) return 255;
      return o;
   endfunction

   task automatic set_zero();
      for (int i = 0; i < 64; i++) rom[i] = 8'd0;
   endtask

   task automatic set_ones();
      set_zero();
      for (int j = 0; j < N_HID; j++) begin
         rom[3*j]         = 8'd1;
         rom[3*j+1]       = 8'd1;
         rom[ADDR_W2 + j] = 8'd1;
      end
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 64; i++) rom[i] = 8'($urandom);
      for (int j = 0; j < N_HID; j++) begin
         rom[3*j]         = 8'(int'($urandom_range(0, 8)) - 4);
         rom[3*j+1]       = 8'(int'($urandom_range(0, 8)) - 4);
         rom[ADDR_W2 + j] = 8'(int'($urandom_range(0, 4)) - 2);
      end
   endtask

   // One job: start in cycle 0, observe cycles 1..44; extra start pulses at p1/p2.
   task automatic run_job(input logic [8:0] a, input logic [8:0] b, input int p1, input int p2);
      logic [7:0] out_init;
      obs_bfirst = -1; obs_blast = -1; obs_bcnt = 0;
      obs_dcyc = -1; obs_ndone = 0; obs_early = 0; obs_res = 8'hxx;
      addr_q.delete();
      @(negedge clk);
      in1 = a; in2 = b; start = 1'b1;
      out_init = out1;
      for (int c = 1; c <= 44; c++) begin
         @(negedge clk);
         if (busy) begin
            if (obs_bfirst < 0) obs_bfirst = c;
            obs_blast = c;
            obs_bcnt++;
         end
         if (coeff_rd) addr_q.push_back(int'(coeff_addr));
         if (done) begin
            if (obs_dcyc < 0) begin
               obs_dcyc = c;
               obs_res = out1;
            end
            obs_ndone++;
         end
         if (obs_dcyc < 0 && out1 !== out_init) obs_early++;
         start = (c == p1 || c == p2);
         in1 = 9'($urandom);
         in2 = 9'($urandom);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
      tests++; if (coeff_rd !== 1'b0) begin fails++; $display("FAIL reset_coeff_rd: got %b want 0", coeff_rd); end
      tests++; if (out1 !== 8'd0) begin fails++; $display("FAIL reset_out1: got %0d want 0", out1); end
      tests++; if (coeff_addr !== 6'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", coeff_addr); end
      tests++; if (act_in !== 17'd0) begin fails++; $display("FAIL reset_acc: got %0d want 0", act_in); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_zero_rom();
      int bad;
      set_zero(); act_mode = 0;
      run_job(9'd100, 9'd100, -1, -1);
      tests++; if (obs_bfirst !== 1) begin fails++; $display("FAIL zero_busy_first: got %0d want 1", obs_bfirst); end
      tests++; if (obs_blast !== 42) begin fails++; $display("FAIL zero_busy_last: got %0d want 42", obs_blast); end
      tests++; if (obs_bcnt !== 42) begin fails++; $display("FAIL zero_busy_count: got %0d want 42", obs_bcnt); end
      tests++; if (obs_dcyc !== 43) begin fails++; $display("FAIL zero_done_cycle: got %0d want 43", obs_dcyc); end
      tests++; if (obs_ndone !== 1) begin fails++; $display("FAIL zero_done_count: got %0d want 1", obs_ndone); end
      tests++; if (obs_res !== 8'd0) begin fails++; $display("FAIL zero_out1: got %0d want 0", obs_res); end
      bad = 0;
      for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != ((i < 40) ? i : 40)) bad++;
      tests++; if (addr_q.size() !== 42 || bad != 0) begin fails++; $display("FAIL zero_addr_seq: got %0d addrs %0d wrong want 42 addrs 0 wrong", addr_q.size(), bad); end
   endtask

   task automatic test_ones();
      set_ones(); act_mode = 0;
      run_job(9'd3, 9'd4, -1, -1);
      tests++; if (obs_dcyc !== 43) begin fails++; $display("FAIL ones_done_cycle: got %0d want 43", obs_dcyc); end
      tests++; if (obs_res !== 8'd70) begin fails++; $display("FAIL ones_out1: got %0d want 70", obs_res); end
      tests++; if (obs_early !== 0) begin fails++; $display("FAIL ones_out1_early: got %0d changes want 0", obs_early); end
   endtask

   task automatic test_clamp();
      int exp_v;
      logic [8:0] va [5] = '{9'd511, 9'd511, 9'd256, 9'd256, 9'd0};
      logic [7:0] w2v [5] = '{8'd1, 8'hFF, 8'd1, 8'd1, 8'd1};
      logic [7:0] b2v [5] = '{8'd0, 8'd0, 8'd0, 8'hFF, 8'hFF};
      for (int k = 0; k < 5; k++) begin
         set_zero(); act_mode = 0;
         if (k < 2) begin
            for (int j = 0; j < N_HID; j++) begin
               rom[3*j] = 8'd1; rom[3*j+1] = 8'd1; rom[ADDR_W2 + j] = w2v[k];
            end
         end else begin
            rom[0] = 8'd1; rom[ADDR_W2] = w2v[k];
         end
         rom[ADDR_B2] = b2v[k];
         exp_v = ref_out(int'(va[k]), int'(va[k]));
         run_job(va[k], (k < 2) ? va[k] : 9'd0, -1, -1);
         tests++; if (obs_dcyc !== 43 || int'(obs_res) != exp_v) begin fails++; $display("FAIL clamp_%0d: got out1=%0d at cycle %0d want %0d at 43", k, obs_res, obs_dcyc, exp_v); end
      end
   endtask

   task automatic test_ignore_start();
      int bad;
      set_ones(); act_mode = 0;
      run_job(9'd3, 9'd4, 5, 20);
      tests++; if (obs_ndone !== 1 || obs_dcyc !== 43) begin fails++; $display("FAIL ignore_done: got %0d dones first %0d want 1 at 43", obs_ndone, obs_dcyc); end
      tests++; if (obs_res !== 8'd70) begin fails++; $display("FAIL ignore_out1: got %0d want 70", obs_res); end
      bad = 0;
      for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != ((i < 40) ? i : 40)) bad++;
      tests++; if (addr_q.size() !== 42 || bad != 0) begin fails++; $display("FAIL ignore_addr_seq: got %0d addrs %0d wrong want 42 addrs 0 wrong", addr_q.size(), bad); end
   endtask

   task automatic test_reset_mid();
      set_ones(); act_mode = 0;
      @(negedge clk);
      in1 = 9'd5; in2 = 9'd6; start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
      tests++; if (out1 !== 8'd0) begin fails++; $display("FAIL midrst_out1: got %0d want 0", out1); end
      tests++; if (coeff_addr !== 6'd0) begin fails++; $display("FAIL midrst_addr: got %0d want 0", coeff_addr); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_job(9'd3, 9'd4, -1, -1);
      tests++; if (obs_dcyc !== 43 || obs_res !== 8'd70) begin fails++; $display("FAIL midrst_rerun: got out1=%0d at cycle %0d want 70 at 43", obs_res, obs_dcyc); end
   endtask

   task automatic test_back_to_back();
      int d1, d2, nd, unstable;
      logic [7:0] r1, r2;
      set_ones(); act_mode = 0;
      d1 = -1; d2 = -1; nd = 0; unstable = 0; r1 = 8'hxx; r2 = 8'hxx;
      @(negedge clk);
      in1 = 9'd3; in2 = 9'd4; start = 1'b1;
      for (int c = 1; c <= 90; c++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (d1 < 0) begin d1 = c; r1 = out1; end
            else if (d2 < 0) begin d2 = c; r2 = out1; end
         end
         if (c > 43 && c < 86 && out1 !== 8'd70) unstable++;
         if (c == 1) begin in1 = 9'd5; in2 = 9'd6; end
         if (c == 86) start = 1'b0;
      end
      start = 1'b0;
      tests++; if (d1 !== 43 || r1 !== 8'd70) begin fails++; $display("FAIL b2b_first: got out1=%0d at cycle %0d want 70 at 43", r1, d1); end
      tests++; if (d2 !== 86 || r2 !== 8'd110) begin fails++; $display("FAIL b2b_second: got out1=%0d at cycle %0d want 110 at 86", r2, d2); end
      tests++; if (nd !== 2 || unstable !== 0) begin fails++; $display("FAIL b2b_stable: got %0d dones %0d unstable want 2 and 0", nd, unstable); end
      repeat (50) @(negedge clk);
   endtask

   task automatic test_random();
      logic [8:0] a, b;
      int exp_v;
      for (int k = 0; k < 12; k++) begin
         fill_rand();
         act_mode = int'($urandom_range(0, 2));
         a = 9'($urandom);
         b = 9'($urandom);
         exp_v = ref_out(int'(a), int'(b));
         run_job(a, b, -1, -1);
         tests++; if (obs_dcyc !== 43 || int'(obs_res) != exp_v) begin fails++; $display("FAIL random_%0d: mode %0d in %0d,%0d got out1=%0d at cycle %0d want %0d at 43", k, act_mode, a, b, obs_res, obs_dcyc, exp_v); end
      end
   endtask

   initial begin
      set_zero();
      test_reset();
      test_zero_rom();
      test_ones();
      test_clamp();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
